conv_block_scheduler: RTL and testbench
=======================================

// Module: conv_block_scheduler
// PURPOSE
//  Sequences the 2D-conv memory/address FSM through LOAD -> PROCESS -> READ for each of
//  i_nBlocks image column blocks. Drives engine i_load/i_SoP/i_valid/i_reset and gates
//  host data strobes. Adds a progress watchdog and abort. Sits between host GPIO and the FSM.
// PARAMETERS
//  NB_IMAGE   10  width of image length (pass-through to engine, informational)
//  NB_BLK     8   width of block count / block index
//  NB_TMO     16  width of watchdog counter
//  TMO_CYC    16'd4096  cycles without progress before ERR (must be > 0)
//  DRAIN_CYC  2   cycles o_SoP held low after EoP before READ starts (>= 1)
// PORTS
//  i_CLK          in   1       clock
//  i_reset        in   1       synchronous, active-high reset
//  i_start        in   1       start pulse; sampled only in IDLE
//  i_abort        in   1       abort; highest priority, any state
//  i_clear        in   1       clears ERR, returns to IDLE
//  i_nBlocks      in   NB_BLK  blocks per image; latched on accepted start
//  i_host_valid   in   1       host data strobe (one per pixel, rising-edge counted by engine)
//  i_changeBlock  in   1       engine: block load/read complete (1-cycle pulse)
//  i_EoP          in   1       engine: end of processing (level)
//  o_load         out  1       engine load request
//  o_SoP          out  1       engine start of processing
//  o_valid        out  1       gated strobe to engine
//  o_eng_reset    out  1       1-cycle engine reset pulse
//  o_blk_idx      out  NB_BLK  current block index
//  o_busy         out  1       high in any state except IDLE/ERR
//  o_done         out  1       1-cycle pulse, image complete
//  o_error        out  1       high while in ERR
// BEHAVIOUR
//  Reset: state IDLE, o_blk_idx=0, watchdog=0, drain=0; all 1-bit outputs 0.
//  Registered outputs decoded from state; o_valid = i_host_valid & (state==LOAD|READ) (comb).
//  States (3 bit): IDLE=0 LOAD=1 PROC=2 DRAIN=3 READ=4 NEXT=5 DONE=6 ERR=7.
//  Priority each edge: i_reset > i_abort > state logic.
//  i_abort (not reset): -> IDLE, o_blk_idx=0, o_eng_reset=1 next cycle only; no o_done.
//  IDLE: i_start & nBlocks!=0 -> LOAD, latch nBlocks, idx=0. i_start & nBlocks==0 -> DONE.
//   o_load high first cycle after edge sampling i_start.
//  LOAD: o_load=1. i_changeBlock -> PROC.
//  PROC: o_SoP=1, o_load=0. i_EoP=1 -> DRAIN.
//  DRAIN: o_SoP=0; count DRAIN_CYC cycles -> READ (i_EoP ignored here).
//  READ: o_load=0,o_SoP=0; i_changeBlock -> NEXT.
//  NEXT (1 cycle): idx==nBlocks_latched-1 -> DONE; else idx+=1 -> LOAD.
//  DONE (1 cycle): o_done=1 -> IDLE; o_blk_idx holds last index until next start.
//  ERR: o_error=1, o_eng_reset=1 on entry cycle only; i_clear -> IDLE (idx=0). i_start ignored.
//  Watchdog: cleared on every state change and on each i_host_valid rising edge in LOAD/READ;
//   increments each cycle in LOAD/PROC/READ; reaching TMO_CYC -> ERR. Saturates, no wrap.
//  Simultaneous: progress event (i_changeBlock / i_EoP) wins over watchdog expiry same cycle.
//  i_start outside IDLE ignored; i_changeBlock outside LOAD/READ ignored.
//  Block index arithmetic NB_BLK unsigned; nBlocks=2^NB_BLK-1 max, idx never wraps.
// TESTING
//  nBlocks=2, 5 host strobes per load/read -> o_load,o_SoP,READ twice; idx 0 then 1; one o_done.
//  start with nBlocks=0 -> o_done at cycle+2, o_load never asserted, o_busy 1 cycle (DONE).
//  TMO_CYC=16, host_valid held low in LOAD -> ERR after 16 cycles, o_error=1, o_eng_reset 1 cycle.
//  abort in PROC -> next cycle o_SoP=0, o_eng_reset=1 one cycle, IDLE, o_busy=0, no o_done.
//  i_changeBlock on same cycle watchdog hits TMO_CYC in LOAD -> PROC entered, o_error stays 0.
//  i_reset mid-READ with idx=1 -> all outputs 0, idx=0; subsequent i_start runs normally.

Source files
------------

// File: rtl/conv_block_scheduler.sv
// Block scheduler for the 2D-conv engine: walks each image column block through LOAD -> PROCESS -> READ.
// It gates host strobes to the engine, enforces a progress watchdog and honours abort and clear.
module conv_block_scheduler #(
    parameter int                NB_IMAGE  = 10,
    parameter int                NB_BLK    = 8,
    parameter int                NB_TMO    = 16,
    parameter logic [NB_TMO-1:0] TMO_CYC   = 16'd4096,
    parameter int                DRAIN_CYC = 2
) (
    input  logic              i_CLK,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_clear,
    input  logic [NB_BLK-1:0] i_nBlocks,
    input  logic              i_host_valid,
    input  logic              i_changeBlock,
    input  logic              i_EoP,
    output logic              o_load,
    output logic              o_SoP,
    output logic              o_valid,
    output logic              o_eng_reset,
    output logic [NB_BLK-1:0] o_blk_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_state
);

    localparam int                DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [NB_TMO-1:0] TMO_LAST   = TMO_CYC - 1'b1;

    if (TMO_CYC == '0 || DRAIN_CYC < 1 || NB_IMAGE < 1) begin : gBadParams
        $error("conv_block_scheduler: TMO_CYC, DRAIN_CYC and NB_IMAGE must be non-zero");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PROC  = 3'd2,
        DRAIN = 3'd3,
        READ  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [NB_BLK-1:0] blkIdx;
    logic [NB_BLK-1:0] nBlocksQ;
    logic [NB_TMO-1:0] wdog;
    logic [DW-1:0]     drainCnt;
    logic              hostValidQ;
    logic              inXfer;
    logic              wdActive;
    logic              hostRise;
    logic              wdExpire;

    assign inXfer    = (state == LOAD) || (state == READ);
    assign wdActive  = inXfer || (state == PROC);
    assign hostRise  = inXfer && i_host_valid && !hostValidQ;
    // A host strobe edge counts as progress, so it also defers expiry in the same cycle.
    assign wdExpire  = wdActive && !hostRise && (wdog == TMO_LAST);
    assign o_valid   = i_host_valid && inXfer;
    assign o_blk_idx = blkIdx;
    assign o_state   = state;

    // Progress events are tested before expiry so they win a same-cycle tie.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (i_start) nextState = (i_nBlocks != '0) ? LOAD : DONE;
            LOAD:    if (i_changeBlock) nextState = PROC;
                     else if (wdExpire) nextState = ERR;
            PROC:    if (i_EoP) nextState = DRAIN;
                     else if (wdExpire) nextState = ERR;
            DRAIN:   if (drainCnt == DRAIN_LAST) nextState = READ;
            READ:    if (i_changeBlock) nextState = NEXT;
                     else if (wdExpire) nextState = ERR;
            NEXT:    nextState = (blkIdx == nBlocksQ - 1'b1) ? DONE : LOAD;
            DONE:    nextState = IDLE;
            ERR:     if (i_clear) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state       <= IDLE;
            blkIdx      <= '0;
            nBlocksQ    <= '0;
            wdog        <= '0;
            drainCnt    <= '0;
            hostValidQ  <= 1'b0;
            o_load      <= 1'b0;
            o_SoP       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_eng_reset <= 1'b0;
        end else if (i_abort) begin
            state       <= IDLE;
            blkIdx      <= '0;
            wdog        <= '0;
            drainCnt    <= '0;
            hostValidQ  <= i_host_valid;
            o_load      <= 1'b0;
            o_SoP       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_eng_reset <= 1'b1;
        end else begin
            state      <= nextState;
            hostValidQ <= i_host_valid;

            if (nextState != state || hostRise) begin
                wdog <= '0;
            end else if (wdActive && wdog != '1) begin
                wdog <= wdog + 1'b1;
            end

            drainCnt <= (state == DRAIN && nextState == DRAIN) ? drainCnt + 1'b1 : '0;

            // After DONE the index is kept for the host until the next start.
            if (state == IDLE && i_start) begin
                nBlocksQ <= i_nBlocks;
                blkIdx   <= '0;
            end else if (state == NEXT && nextState == LOAD) begin
                blkIdx <= blkIdx + 1'b1;
            end else if (state == ERR && nextState == IDLE) begin
                blkIdx <= '0;
            end

            o_load      <= (nextState == LOAD);
            o_SoP       <= (nextState == PROC);
            o_busy      <= (nextState != IDLE) && (nextState != ERR);
            o_done      <= (nextState == DONE);
            o_error     <= (nextState == ERR);
            o_eng_reset <= (nextState == ERR) && (state != ERR);
        end
    end

endmodule

// File: tb/tb_conv_block_scheduler.sv
// Bench for conv_block_scheduler: the bench plays host and engine, and an event scoreboard
// checks load/SoP/done/error/engine-reset rises together with the block index at each rise.
module tb_conv_block_scheduler;

    localparam int NB_BLK = 8;
    localparam logic [3:0] EV_LOAD = 4'd1;
    localparam logic [3:0] EV_SOP  = 4'd2;
    localparam logic [3:0] EV_DONE = 4'd3;
    localparam logic [3:0] EV_ERR  = 4'd4;
    localparam logic [3:0] EV_ERST = 4'd5;

    logic              i_CLK;
    logic              i_reset;
    logic              i_start;
    logic              i_abort;
    logic              i_clear;
    logic [NB_BLK-1:0] i_nBlocks;
    logic              i_host_valid;
    logic              i_changeBlock;
    logic              i_EoP;
    logic              o_load;
    logic              o_SoP;
    logic              o_valid;
    logic              o_eng_reset;
    logic [NB_BLK-1:0] o_blk_idx;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [2:0]        dbgState;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    conv_block_scheduler #(
        .NB_IMAGE (10),
        .NB_BLK   (NB_BLK),
        .NB_TMO   (16),
        .TMO_CYC  (16'd16),
        .DRAIN_CYC(2)
    ) dut (
        .i_CLK        (i_CLK),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_clear      (i_clear),
        .i_nBlocks    (i_nBlocks),
        .i_host_valid (i_host_valid),
        .i_changeBlock(i_changeBlock),
        .i_EoP        (i_EoP),
        .o_load       (o_load),
        .o_SoP        (o_SoP),
        .o_valid      (o_valid),
        .o_eng_reset  (o_eng_reset),
        .o_blk_idx    (o_blk_idx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_state      (dbgState)
    );

    // clock / reset
    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic push_ev(input logic [3:0] ev, input int idx);
        exp_q.push_back({ev, 8'(idx)});
    endtask

    // monitor
    logic pLoad = 1'b0, pSop = 1'b0, pDone = 1'b0, pErr = 1'b0, pErst = 1'b0;

    task automatic sb_pop(input logic [3:0] ev);
        logic [11:0] obs;
        logic [11:0] expv;
        obs = {ev, o_blk_idx};
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got %0h want none", obs);
        end else begin
            expv = exp_q.pop_front();
            check("scoreboard", 32'(obs), 32'(expv));
        end
    endtask

    always @(negedge i_CLK) begin
        if (o_load === 1'b1 && !pLoad) sb_pop(EV_LOAD);
        if (o_SoP === 1'b1 && !pSop) sb_pop(EV_SOP);
        if (o_done === 1'b1 && !pDone) sb_pop(EV_DONE);
        if (o_error === 1'b1 && !pErr) sb_pop(EV_ERR);
        if (o_eng_reset === 1'b1 && !pErst) sb_pop(EV_ERST);
        pLoad = (o_load === 1'b1);
        pSop  = (o_SoP === 1'b1);
        pDone = (o_done === 1'b1);
        pErr  = (o_error === 1'b1);
        pErst = (o_eng_reset === 1'b1);
    end

    // driver tasks
    task automatic wait_sig(input int which, input string name);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            @(negedge i_CLK);
            case (which)
                0:       hit = (o_load === 1'b1);
                1:       hit = (o_SoP === 1'b1);
                default: hit = (o_done === 1'b1);
            endcase
            n++;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic start_img(input int n);
        tick();
        i_nBlocks = 8'(n);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_nBlocks = 8'($urandom);
    endtask

    task automatic xfer_strobes(input int ns, input bit ignStart, input string name);
        int k;
        k = (ns > 0) ? ns : $urandom_range(1, 6);
        for (int s = 0; s < k; s++) begin
            tick();
            i_host_valid = 1'b1;
            if (ignStart && s == 0) i_start = 1'b1;
            @(negedge i_CLK);
            check(name, 32'(o_valid), 32'd1);
            tick();
            i_host_valid = 1'b0;
            i_start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();
        i_changeBlock = 1'b1;
        tick();
        i_changeBlock = 1'b0;
    endtask

    task automatic do_load(input int b, input int ns, input bit ignStart);
        wait_sig(0, "load_wait");
        check("load_idx", 32'(o_blk_idx), 32'(b));
        xfer_strobes(ns, ignStart, "load_valid");
    endtask

    // PROC, then EoP held through DRAIN with the host strobe high; READ follows DRAIN_CYC edges later.
    task automatic do_proc_drain();
        wait_sig(1, "sop_wait");
        repeat ($urandom_range(0, 5)) tick();
        if ($urandom_range(0, 1) == 1) begin
            tick();
            i_changeBlock = 1'b1;
            tick();
            i_changeBlock = 1'b0;
        end
        tick();
        i_EoP = 1'b1;
        tick();
        i_host_valid = 1'b1;
        @(negedge i_CLK);
        check("drain_gate0", 32'(o_valid), 32'd0);
        check("drain_sop", 32'(o_SoP), 32'd0);
        tick();
        @(negedge i_CLK);
        check("drain_gate1", 32'(o_valid), 32'd0);
        tick();
        i_host_valid = 1'b0;
        i_EoP = 1'b0;
    endtask

    task automatic run_image(input int n, input int ns);
        for (int b = 0; b < n; b++) begin
            push_ev(EV_LOAD, b);
            push_ev(EV_SOP, b);
        end
        push_ev(EV_DONE, n - 1);
        start_img(n);
        for (int b = 0; b < n; b++) begin
            do_load(b, ns, (ns == 0) && ($urandom_range(0, 1) == 1));
            do_proc_drain();
            xfer_strobes(ns, 1'b0, "read_valid");
        end
        wait_sig(2, "done_wait");
        @(negedge i_CLK);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_idx_hold", 32'(o_blk_idx), 32'(n - 1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_load"}, 32'(o_load), 32'd0);
        check({name, "_sop"}, 32'(o_SoP), 32'd0);
        check({name, "_valid"}, 32'(o_valid), 32'd0);
        check({name, "_erst"}, 32'(o_eng_reset), 32'd0);
        check({name, "_idx"}, 32'(o_blk_idx), 32'd0);
        check({name, "_busy"}, 32'(o_busy), 32'd0);
        check({name, "_done"}, 32'(o_done), 32'd0);
        check({name, "_error"}, 32'(o_error), 32'd0);
    endtask

    initial begin
        int cnt;
        int busyCnt;
        int loadCnt;
        int doneAt;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_clear = 1'b0;
        i_nBlocks = '0;
        i_host_valid = 1'b0;
        i_changeBlock = 1'b0;
        i_EoP = 1'b0;
        repeat (3) tick();
        @(negedge i_CLK);
        check_all_zero("reset");
        check("reset_state", 32'(dbgState), 32'd0);
        tick();
        i_reset = 1'b0;

        // two blocks, five strobes per transfer
        run_image(2, 5);

        // zero blocks: straight to DONE for one cycle
        push_ev(EV_DONE, 0);
        tick();
        i_nBlocks = 8'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        busyCnt = 0;
        loadCnt = 0;
        doneAt = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_CLK);
            if (o_busy) busyCnt++;
            if (o_load) loadCnt++;
            if (o_done && doneAt < 0) doneAt = k;
        end
        check("zero_done_at", 32'(doneAt), 32'd0);
        check("zero_busy_cycles", 32'(busyCnt), 32'd1);
        check("zero_load_cycles", 32'(loadCnt), 32'd0);

        // watchdog expiry in the second LOAD
        push_ev(EV_LOAD, 0);
        push_ev(EV_SOP, 0);
        push_ev(EV_LOAD, 1);
        push_ev(EV_ERR, 1);
        push_ev(EV_ERST, 1);
        start_img(3);
        do_load(0, 4, 1'b0);
        do_proc_drain();
        xfer_strobes(4, 1'b0, "read_valid");
        wait_sig(0, "tmo_load_wait");
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_CLK);
            if (o_error) break;
            cnt++;
        end
        check("tmo_load_cycles", 32'(cnt), 32'd16);
        check("tmo_erst_entry", 32'(o_eng_reset), 32'd1);
        check("tmo_busy", 32'(o_busy), 32'd0);
        @(negedge i_CLK);
        check("tmo_erst_once", 32'(o_eng_reset), 32'd0);
        check("tmo_error_held", 32'(o_error), 32'd1);
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        @(negedge i_CLK);
        check("err_start_ignored", 32'(o_error), 32'd1);
        check("err_no_load", 32'(o_load), 32'd0);
        tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        @(negedge i_CLK);
        check("clear_error", 32'(o_error), 32'd0);
        check("clear_busy", 32'(o_busy), 32'd0);
        check("clear_idx", 32'(o_blk_idx), 32'd0);

        // abort while processing
        push_ev(EV_LOAD, 0);
        push_ev(EV_SOP, 0);
        push_ev(EV_ERST, 0);
        start_img(2);
        do_load(0, 3, 1'b0);
        wait_sig(1, "abort_sop_wait");
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge i_CLK);
        check("abort_sop", 32'(o_SoP), 32'd0);
        check("abort_erst", 32'(o_eng_reset), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_idx", 32'(o_blk_idx), 32'd0);
        @(negedge i_CLK);
        check("abort_erst_once", 32'(o_eng_reset), 32'd0);
        repeat (5) tick();

        // block change on the very edge the watchdog would expire
        push_ev(EV_LOAD, 0);
        push_ev(EV_SOP, 0);
        push_ev(EV_DONE, 0);
        start_img(1);
        wait_sig(0, "race_load_wait");
        repeat (15) tick();
        i_changeBlock = 1'b1;
        tick();
        i_changeBlock = 1'b0;
        @(negedge i_CLK);
        check("race_sop", 32'(o_SoP), 32'd1);
        check("race_error", 32'(o_error), 32'd0);
        do_proc_drain();
        xfer_strobes(3, 1'b0, "read_valid");
        wait_sig(2, "race_done_wait");

        // reset in the middle of the second READ
        push_ev(EV_LOAD, 0);
        push_ev(EV_SOP, 0);
        push_ev(EV_LOAD, 1);
        push_ev(EV_SOP, 1);
        start_img(3);
        do_load(0, 2, 1'b0);
        do_proc_drain();
        xfer_strobes(2, 1'b0, "read_valid");
        do_load(1, 2, 1'b0);
        do_proc_drain();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        @(negedge i_CLK);
        check_all_zero("midreset");
        run_image(2, 4);

        // randomized images
        for (int r = 0; r < 8; r++) begin
            run_image($urandom_range(1, 4), 0);
        end

        repeat (4) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
